// File: rtl/lector_banco_reg_if.sv
// lector_banco_reg_if
//   Bundles the controller handshake (start/busy/done) and the register-bank
//   read bus (dir/rd_en/dato_banco) seen by the read-back sequencer.
//   Handshake: the controller raises start; it is sampled only while the
//   sequencer is idle (busy=0). busy stays high from the cycle after start is
//   accepted until the done cycle ends. done is a one-cycle pulse. rd_en is a
//   one-cycle strobe qualifying dir. dato_banco must be valid RD_LAT cycles
//   after the edge that sampled rd_en high.
//   modport master : the sequencer (drives dir, rd_en, busy, done)
//   modport slave  : controller + bank side (drives start, dato_banco)
interface lector_banco_reg_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] dir;
  logic       rd_en;
  logic [7:0] dato_banco;

  modport master (
    input  start,
    input  dato_banco,
    output busy,
    output done,
    output dir,
    output rd_en
  );

  modport slave (
    output start,
    output dato_banco,
    input  busy,
    input  done,
    input  dir,
    input  rd_en
  );
endinterface

// File: rtl/lector_banco_reg.sv
// lector_banco_reg
//   Read-back sequencer. On start it walks bank addresses 0..8, issues one
//   read per address and demuxes each returned byte into its holding register
//   (RTC time/date and timer hh:mm:ss).
//   Optional feature macro: LECTOR_BCD_CHECK_EN -- rejects non-BCD bytes
//   (old value kept) and raises a sticky bcd_err until the next sweep starts.
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   bus         : lector_banco_reg_if.master (start/busy/done, dir/rd_en/dato_banco)
//   seg_rt..ao  : RTC seconds, minutes, hours, day, month, year (addr 0..5)
//   seg_tm..hor_tm : timer seconds, minutes, hours (addr 6..8)
//   bcd_err     : sticky non-BCD flag (tied 0 without the macro)
//   fsm_state   : current FSM state encoding, for debug/observation
// Parameter
//   RD_LAT      : bank read latency in cycles, legal 1..4
module lector_banco_reg #(
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  lector_banco_reg_if.master        bus,
  output logic [7:0]                seg_rt,
  output logic [7:0]                min_rt,
  output logic [7:0]                hor_rt,
  output logic [7:0]                dia,
  output logic [7:0]                mes,
  output logic [7:0]                ao,
  output logic [7:0]                seg_tm,
  output logic [7:0]                min_tm,
  output logic [7:0]                hor_tm,
  output logic                      bcd_err,
  output logic [2:0]                fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);
  localparam logic [3:0] LAST_ADDR = 4'd8;

  state_t     state, state_nxt;
  logic [3:0] addr, addr_nxt;
  logic [2:0] wait_cnt, wait_cnt_nxt;
  logic       capture;
  logic       dato_ok;

  assign fsm_state = state;
  // The address counter doubles as the bank address, so dir naturally holds
  // its last issued value while idle.
  assign bus.dir   = addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      addr     <= 4'd0;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    wait_cnt_nxt = wait_cnt;
    bus.rd_en    = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    capture      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          addr_nxt  = 4'd0;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.rd_en    = 1'b1;
        wait_cnt_nxt = WAIT_LOAD;
        state_nxt    = (RD_LAT == 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        // RD_LAT-1 wait cycles: leave when the decremented count hits 0.
        wait_cnt_nxt = wait_cnt - 3'd1;
        if (wait_cnt <= 3'd1) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture = 1'b1;
        if (addr == LAST_ADDR) begin
          state_nxt = S_DONE;
        end else begin
          addr_nxt  = addr + 4'd1;
          state_nxt = S_ISSUE;
        end
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef LECTOR_BCD_CHECK_EN
  assign dato_ok = (bus.dato_banco[7:4] <= 4'd9) && (bus.dato_banco[3:0] <= 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_err <= 1'b0;
    end else if (state == S_IDLE && bus.start) begin
      bcd_err <= 1'b0;
    end else if (capture && !dato_ok) begin
      bcd_err <= 1'b1;
    end
  end
`else
  assign dato_ok = 1'b1;
  assign bcd_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_rt <= 8'd0;
      min_rt <= 8'd0;
      hor_rt <= 8'd0;
      dia    <= 8'd0;
      mes    <= 8'd0;
      ao     <= 8'd0;
      seg_tm <= 8'd0;
      min_tm <= 8'd0;
      hor_tm <= 8'd0;
    end else if (capture && dato_ok) begin
      case (addr)
        4'd0:    seg_rt <= bus.dato_banco;
        4'd1:    min_rt <= bus.dato_banco;
        4'd2:    hor_rt <= bus.dato_banco;
        4'd3:    dia    <= bus.dato_banco;
        4'd4:    mes    <= bus.dato_banco;
        4'd5:    ao     <= bus.dato_banco;
        4'd6:    seg_tm <= bus.dato_banco;
        4'd7:    min_tm <= bus.dato_banco;
        4'd8:    hor_tm <= bus.dato_banco;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lector_banco_reg.sv
// tb_lector_banco_reg
//   Directed bench for lector_banco_reg. Two instances: dut_a (RD_LAT=1) and
//   dut_b (RD_LAT=3) share clock, reset and a bank model whose read data
//   appears RD_LAT cycles after the rd_en edge. Inputs change on the falling
//   edge; outputs are sampled on the falling edge.
module tb_lector_banco_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  lector_banco_reg_if if_a ();
  lector_banco_reg_if if_b ();

  wire [8:0][7:0] regs_a, regs_b;
  wire            err_a, err_b;
  wire [2:0]      st_a, st_b;

  lector_banco_reg #(.RD_LAT(1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (if_a.master),
    .seg_rt    (regs_a[0]),
    .min_rt    (regs_a[1]),
    .hor_rt    (regs_a[2]),
    .dia       (regs_a[3]),
    .mes       (regs_a[4]),
    .ao        (regs_a[5]),
    .seg_tm    (regs_a[6]),
    .min_tm    (regs_a[7]),
    .hor_tm    (regs_a[8]),
    .bcd_err   (err_a),
    .fsm_state (st_a)
  );

  lector_banco_reg #(.RD_LAT(3)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (if_b.master),
    .seg_rt    (regs_b[0]),
    .min_rt    (regs_b[1]),
    .hor_rt    (regs_b[2]),
    .dia       (regs_b[3]),
    .mes       (regs_b[4]),
    .ao        (regs_b[5]),
    .seg_tm    (regs_b[6]),
    .min_tm    (regs_b[7]),
    .hor_tm    (regs_b[8]),
    .bcd_err   (err_b),
    .fsm_state (st_b)
  );

  // ---------------- bank model ----------------
  logic [7:0] bank [16];
  logic       pa_v = 1'b0;
  logic [3:0] pa_addr = 4'd0;
  logic       pb_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [3:0] pb_addr [3] = '{4'd0, 4'd0, 4'd0};

  always @(posedge clk) begin
    pa_v       <= if_a.rd_en;
    pa_addr    <= if_a.dir;
    pb_v[0]    <= if_b.rd_en;
    pb_addr[0] <= if_b.dir;
    for (int i = 1; i < 3; i++) begin
      pb_v[i]    <= pb_v[i-1];
      pb_addr[i] <= pb_addr[i-1];
    end
  end

  // 8'hEE outside the valid window so an early/late capture is visible.
  assign if_a.dato_banco = pa_v    ? bank[pa_addr]    : 8'hEE;
  assign if_b.dato_banco = pb_v[2] ? bank[pb_addr[2]] : 8'hEE;

  // ---------------- observation mux ----------------
  int             sel;
  logic           cur_rd, cur_busy, cur_done, cur_err;
  logic [3:0]     cur_dir;
  logic [8:0][7:0] cur_regs;

  always_comb begin
    if (sel == 0) begin
      cur_rd = if_a.rd_en; cur_busy = if_a.busy; cur_done = if_a.done;
      cur_dir = if_a.dir; cur_err = err_a; cur_regs = regs_a;
    end else begin
      cur_rd = if_b.rd_en; cur_busy = if_b.busy; cur_done = if_b.done;
      cur_dir = if_b.dir; cur_err = err_b; cur_regs = regs_b;
    end
  end

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 9; i++) begin
      check_val($sformatf("%s reg%0d", tag, i), cur_regs[i], exp_q.pop_front());
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, " busy"}, cur_busy, 0);
    check_val({tag, " done"}, cur_done, 0);
    check_val({tag, " rd_en"}, cur_rd, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_start(input logic v);
    if (sel == 0) if_a.start = v;
    else          if_b.start = v;
  endtask

  task automatic fill_bank(input logic [7:0] base);
    for (int i = 0; i < 16; i++) bank[i] = base + 8'(i);
  endtask

  // Called at a falling edge with the selected DUT idle. The next rising edge
  // accepts start; cycle k is the k-th cycle after that edge (k=1 is ISSUE of
  // addr 0). Every cycle up to the expected done cycle is checked.
  task automatic run_sweep(input int lat, input bit hold);
    int per;
    int exp_done;
    bit exp_rd;
    per      = 1 + lat;
    exp_done = 9 * per + 1;
    set_start(1'b1);
    @(posedge clk);
    for (int k = 1; k <= exp_done; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) set_start(1'b0);
      exp_rd = (k <= 9 * per) && ((k - 1) % per == 0);
      check_val($sformatf("lat%0d rd_en k%0d", lat, k), cur_rd, exp_rd);
      if (exp_rd) check_val($sformatf("lat%0d dir k%0d", lat, k), cur_dir, (k - 1) / per);
      check_val($sformatf("lat%0d done k%0d", lat, k), cur_done, k == exp_done);
      check_val($sformatf("lat%0d busy k%0d", lat, k), cur_busy, 1);
      if (k == 1) check_val($sformatf("lat%0d bcd_err clr", lat), cur_err, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sel        = 0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    reset      = 1'b1;
    fill_bank(8'h00);
    repeat (3) @(negedge clk);

    // reset state of both instances
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check_idle($sformatf("rst%0d", s));
      check_val($sformatf("rst%0d dir", s), cur_dir, 0);
      check_val($sformatf("rst%0d bcd_err", s), cur_err, 0);
      for (int i = 0; i < 9; i++) exp_q.push_back(8'h00);
      check_regs($sformatf("rst%0d", s));
    end
    sel = 0;
    reset = 1'b0;
    @(negedge clk);

    // RD_LAT=1 basic sweep
    fill_bank(8'h10);
    run_sweep(1, 1'b0);
    @(negedge clk);
    check_idle("t1 post");
    check_val("t1 dir hold", cur_dir, 8);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h10 + 8'(i));
    check_regs("t1");

    // RD_LAT=3 sweep
    sel = 1;
    #1;
    run_sweep(3, 1'b0);
    @(negedge clk);
    check_idle("t2 post");
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h10 + 8'(i));
    check_regs("t2");
    sel = 0;
    #1;

    // start held high: one done per sweep, restart after the idle cycle
    fill_bank(8'h40);
    run_sweep(1, 1'b1);
    @(negedge clk);
    check_idle("t3 gap");
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h40 + 8'(i));
    check_regs("t3a");
    fill_bank(8'h50);
    run_sweep(1, 1'b1);
    set_start(1'b0);
    @(negedge clk);
    check_idle("t3 end");
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h50 + 8'(i));
    check_regs("t3b");

    // reset during CAPTURE of addr 4 (cycle k=10)
    set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0);
    repeat (9) @(negedge clk);
    check_val("t4 dir at capture", cur_dir, 4);
    check_val("t4 rd_en at capture", cur_rd, 0);
    reset = 1'b1;
    @(negedge clk);
    check_idle("t4 rst");
    check_val("t4 rst dir", cur_dir, 0);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h00);
    check_regs("t4 rst");
    reset = 1'b0;
    @(negedge clk);
    fill_bank(8'h20);
    bank[3] = 8'h15;
    run_sweep(1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 9; i++) exp_q.push_back(i == 3 ? 8'h15 : 8'h20 + 8'(i));
    check_regs("t4 restart");

    // non-BCD bytes at addr 2 and 3
    fill_bank(8'h30);
    bank[2] = 8'hFF;
    bank[3] = 8'h3A;
    run_sweep(1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h30 + 8'(i));
`ifdef LECTOR_BCD_CHECK_EN
    exp_q[2] = 8'h22;
    exp_q[3] = 8'h15;
    check_val("t5 bcd_err set", cur_err, 1);
`else
    exp_q[2] = 8'hFF;
    exp_q[3] = 8'h3A;
    check_val("t6 bcd_err tied", cur_err, 0);
`endif
    check_regs("t5");

    // next sweep clears the flag on accept
    fill_bank(8'h10);
    run_sweep(1, 1'b0);
    @(negedge clk);
    check_val("t5 bcd_err after clean", cur_err, 0);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h10 + 8'(i));
    check_regs("t5 clean");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
